pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable, bubble and flush controls of the PC, the IF/ID register and the ID/EX control-signal register (the stage-2 control latch). It detects load-use hazards and taken branches/jumps resolved in ID. It also runs a req/ack handshake FSM that freezes the whole pipeline while a multi-cycle data-memory access in MEM is outstanding.

---
 rtl/pipeline_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, ID redirects,
// and a req/ack freeze while a multi-cycle data-memory access is outstanding.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             Mem_ack_i,
    output logic             Mem_req_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             Pipe_hold_o,
    output logic             Mem_err_o,
    output logic [CNT_W-1:0] Stall_cnt_o,
    output logic [CNT_W-1:0] Flush_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_d;
    logic              mem_op;
    logic              lu;
    logic              redirect;

    assign mem_op   = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign lu       = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
    assign redirect = Branch_taken_i | Jump_i;

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            wait_q    <= '0;
            Mem_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            Mem_err_o <= err_d;
        end
    end

    // Next state and pipeline controls; memory freeze outranks load-use, which outranks redirect
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = Mem_err_o;
        Mem_req_o     = 1'b0;
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        Pipe_hold_o   = 1'b0;
        case (state_q)
            RUN: begin
                Mem_req_o = mem_op;
                if (mem_op && !Mem_ack_i) begin
                    Pipe_hold_o  = 1'b1;
                    PC_write_o   = 1'b0;
                    IFID_write_o = 1'b0;
                    state_d      = MEM_WAIT;
                    wait_d       = WAIT_W'(1);
                end else if (lu) begin
                    PC_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                end else if (redirect) begin
                    IFID_flush_o = 1'b1;
                end
            end
            MEM_WAIT: begin
                Mem_req_o    = 1'b1;
                Pipe_hold_o  = 1'b1;
                PC_write_o   = 1'b0;
                IFID_write_o = 1'b0;
                if (Mem_ack_i) begin
                    state_d = RUN;
                end else begin
                    if (wait_q < WAIT_W'(MEM_TIMEOUT)) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                    if (wait_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Saturating event counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            Stall_cnt_o <= '0;
            Flush_cnt_o <= '0;
        end else begin
            if (!PC_write_o && (Stall_cnt_o != '1)) begin
                Stall_cnt_o <= Stall_cnt_o + CNT_W'(1);
            end
            if (IFID_flush_o && (Flush_cnt_o != '1)) begin
                Flush_cnt_o <= Flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes model predictions,
// monitor pops and compares every cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned TIMEOUT = 4;
    localparam int          SAT     = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             IDEX_MemRead_i = 1'b0;
    logic [4:0]       IDEX_Rt_i = '0;
    logic [4:0]       IFID_Rs_i = '0;
    logic [4:0]       IFID_Rt_i = '0;
    logic             Branch_taken_i = 1'b0;
    logic             Jump_i = 1'b0;
    logic             EXMEM_MemRead_i = 1'b0;
    logic             EXMEM_MemWrite_i = 1'b0;
    logic             Mem_ack_i = 1'b0;
    logic             Mem_req_o, PC_write_o, IFID_write_o, IFID_flush_o;
    logic             IDEX_bubble_o, Pipe_hold_o, Mem_err_o;
    logic [CNT_W-1:0] Stall_cnt_o, Flush_cnt_o;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_Rt_i(IDEX_Rt_i),
        .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
        .Branch_taken_i(Branch_taken_i), .Jump_i(Jump_i),
        .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
        .Mem_ack_i(Mem_ack_i), .Mem_req_o(Mem_req_o), .PC_write_o(PC_write_o),
        .IFID_write_o(IFID_write_o), .IFID_flush_o(IFID_flush_o),
        .IDEX_bubble_o(IDEX_bubble_o), .Pipe_hold_o(Pipe_hold_o),
        .Mem_err_o(Mem_err_o), .Stall_cnt_o(Stall_cnt_o), .Flush_cnt_o(Flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        bit req, pc, ifid, flush, bubble, hold, err;
        int stalls, flushes;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    // Reference model: waiting flag, cycles spent waiting, sticky error, event totals
    bit m_wait  = 0;
    int m_waits = 0;
    bit m_err   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string name, input int c, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL cyc %0d %s: got %0d expected %0d", c, name, got, want);
    endtask

    task automatic drive(input bit rst, input bit mr, input int rt, input int rs,
                         input int irt, input bit bt, input bit jp, input bit emr,
                         input bit emw, input bit ack);
        exp_t e;
        bit   mem_op, lu, freeze;
        @(negedge clk_i);
        rst_i = rst; IDEX_MemRead_i = mr; IDEX_Rt_i = 5'(rt); IFID_Rs_i = 5'(rs);
        IFID_Rt_i = 5'(irt); Branch_taken_i = bt; Jump_i = jp;
        EXMEM_MemRead_i = emr; EXMEM_MemWrite_i = emw; Mem_ack_i = ack;
        cyc++;
        if (!rst) begin
            m_wait = 0; m_waits = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end
        mem_op = emr || emw;
        lu     = mr && rt != 0 && (rt == rs || rt == irt);
        freeze = m_wait || (mem_op && !ack);
        e.cyc = cyc; e.err = m_err; e.stalls = m_stall; e.flushes = m_flush;
        e.req = m_wait || mem_op;
        e.hold = freeze;
        e.pc = !freeze && !lu;
        e.ifid = e.pc;
        e.bubble = !freeze && lu;
        e.flush = !freeze && !lu && (bt || jp);
        q.push_back(e);
        if (rst) begin
            if (m_wait) begin
                if (ack) m_wait = 0;
                else begin
                    m_waits++;
                    if (m_waits >= TIMEOUT) m_err = 1;
                end
            end else if (freeze) begin
                m_wait = 1; m_waits = 1;
            end
            if (!e.pc) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
            if (e.flush) m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle once inputs settle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("Mem_req", e.cyc, int'(Mem_req_o), int'(e.req));
                chk("PC_write", e.cyc, int'(PC_write_o), int'(e.pc));
                chk("IFID_write", e.cyc, int'(IFID_write_o), int'(e.ifid));
                chk("IFID_flush", e.cyc, int'(IFID_flush_o), int'(e.flush));
                chk("IDEX_bubble", e.cyc, int'(IDEX_bubble_o), int'(e.bubble));
                chk("Pipe_hold", e.cyc, int'(Pipe_hold_o), int'(e.hold));
                chk("Mem_err", e.cyc, int'(Mem_err_o), int'(e.err));
                chk("Stall_cnt", e.cyc, int'(Stall_cnt_o), e.stalls);
                chk("Flush_cnt", e.cyc, int'(Flush_cnt_o), e.flushes);
            end
        end
    end

    initial begin
        int budget;
        // reset, then idle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use single bubble
        drive(1, 1, 5, 5, 0, 0, 0, 0, 0, 0);
        idle(2);
        // $0 never stalls
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        idle(1);
        // branch suppressed under load-use, then taken
        drive(1, 1, 7, 0, 7, 1, 0, 0, 0, 0);
        drive(1, 0, 7, 0, 7, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        // memory wait: 3 nack cycles then ack
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        idle(2);
        // same-cycle ack does not freeze
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // timeout: error sticks past the ack
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        // async reset mid-wait
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // counter saturation
        for (int i = 0; i < SAT + 5; i++) drive(1, 1, 9, 0, 9, 0, 0, 0, 0, 0);
        for (int i = 0; i < SAT + 5; i++) drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) < 3));
        end
        idle(1);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        #5;
        if (q.size() > 0) chk("drain", cyc, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
